// File: rtl/pipe_stage_buff_if.sv
// Valid/ready stream bundle carrying a data payload and a control payload.
// The producer side uses the master modport, the consumer side the slave modport.
interface pipe_stage_buff_if #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 16
);

    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;

    modport master (
        output valid,
        output data,
        output ctrl,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  ctrl,
        output ready
    );

endinterface

// File: rtl/pipe_stage_buff.sv
// Pipeline stage register with a two-entry skid buffer.
// The main register drives the downstream side. The skid register absorbs the
// one extra entry that upstream may send before it sees the registered inReady
// fall, so there is no combinational path from outReady to inReady.
// Control fields read zero on every bubble, so a bubble never asserts a write enable.
module pipe_stage_buff #(
    parameter int DATA_W     = 128,
    parameter int CTRL_W     = 16,
    parameter bit CLEAR_DATA = 1'b0,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    pipe_stage_buff_if.slave  up,
    pipe_stage_buff_if.master dn,
    output logic [CNT_W-1:0] stallCnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    state_t nextState;

    logic accept;
    logic emit;

    logic outValidReg;
    logic inReadyReg;

    logic [DATA_W-1:0] mainData;
    logic [CTRL_W-1:0] mainCtrl;
    logic [DATA_W-1:0] skidData;
    logic [CTRL_W-1:0] skidCtrl;

    logic mainLoadIn;
    logic mainLoadSkid;
    logic mainClear;
    logic skidLoadIn;
    logic skidClear;

    assign accept = up.valid & inReadyReg;
    assign emit   = outValidReg & dn.ready;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= EMPTY;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; flush overrides every handshake transition.
    always_comb begin
        nextState = state;
        if (flush) begin
            nextState = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        nextState = ONE;
                    end
                end
                ONE: begin
                    if (accept && !emit) begin
                        nextState = FULL;
                    end else if (!accept && emit) begin
                        nextState = EMPTY;
                    end
                end
                FULL: begin
                    if (emit) begin
                        nextState = ONE;
                    end
                end
                default: begin
                    nextState = EMPTY;
                end
            endcase
        end
    end

    // Datapath steering decoded from the current state and this cycle's handshakes.
    always_comb begin
        mainLoadIn   = 1'b0;
        mainLoadSkid = 1'b0;
        mainClear    = 1'b0;
        skidLoadIn   = 1'b0;
        skidClear    = 1'b0;
        if (flush) begin
            mainClear = 1'b1;
            skidClear = 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    mainLoadIn = accept;
                end
                ONE: begin
                    if (accept && emit) begin
                        mainLoadIn = 1'b1;
                    end else if (accept) begin
                        skidLoadIn = 1'b1;
                    end else if (emit) begin
                        mainClear = 1'b1;
                    end
                end
                FULL: begin
                    if (emit) begin
                        mainLoadSkid = 1'b1;
                        skidClear    = 1'b1;
                    end
                end
                default: begin
                    mainClear = 1'b1;
                    skidClear = 1'b1;
                end
            endcase
        end
    end

    // Registered handshake flags, computed from the next state so both are pure flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outValidReg <= 1'b0;
            inReadyReg  <= 1'b1;
        end else begin
            outValidReg <= (nextState != EMPTY);
            inReadyReg  <= (nextState != FULL);
        end
    end

    // Main register: takes the new entry, the skid entry, or empties to a bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mainData <= '0;
            mainCtrl <= '0;
        end else if (mainLoadIn) begin
            mainData <= up.data;
            mainCtrl <= up.ctrl;
        end else if (mainLoadSkid) begin
            mainData <= skidData;
            mainCtrl <= skidCtrl;
        end else if (mainClear) begin
            mainCtrl <= '0;
            if (CLEAR_DATA) begin
                mainData <= '0;
            end
        end
    end

    // Skid register: catches the entry that arrives while downstream is stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            skidData <= '0;
            skidCtrl <= '0;
        end else if (skidLoadIn) begin
            skidData <= up.data;
            skidCtrl <= up.ctrl;
        end else if (skidClear) begin
            skidCtrl <= '0;
            if (CLEAR_DATA) begin
                skidData <= '0;
            end
        end
    end

    // Saturating count of cycles where downstream holds off a valid entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stallCnt <= '0;
        end else if (outValidReg && !dn.ready && (stallCnt != {CNT_W{1'b1}})) begin
            stallCnt <= stallCnt + CNT_W'(1);
        end
    end

    assign up.ready = inReadyReg;
    assign dn.valid = outValidReg;
    assign dn.data  = mainData;
    assign dn.ctrl  = outValidReg ? mainCtrl : '0;

endmodule

// File: tb/tb_pipe_stage_buff.sv
// Directed bench for pipe_stage_buff. Two instances share the same stimulus:
// dut0 keeps data on flush/drain with a 16-bit stall counter, dut1 clears data
// and uses a 4-bit stall counter so saturation is reached quickly.
module tb_pipe_stage_buff;

    logic         clk;
    logic         reset_n;
    logic         flush;
    logic         inValid;
    logic [127:0] inData;
    logic [15:0]  inCtrl;
    logic         outReady;
    logic [15:0]  stallCnt0;
    logic [3:0]   stallCnt1;

    int checks;
    int failures;

    pipe_stage_buff_if #(.DATA_W(128), .CTRL_W(16)) up0 ();
    pipe_stage_buff_if #(.DATA_W(128), .CTRL_W(16)) dn0 ();
    pipe_stage_buff_if #(.DATA_W(128), .CTRL_W(16)) up1 ();
    pipe_stage_buff_if #(.DATA_W(128), .CTRL_W(16)) dn1 ();

    assign up0.valid = inValid;
    assign up0.data  = inData;
    assign up0.ctrl  = inCtrl;
    assign up1.valid = inValid;
    assign up1.data  = inData;
    assign up1.ctrl  = inCtrl;
    assign dn0.ready = outReady;
    assign dn1.ready = outReady;

    pipe_stage_buff #(
        .DATA_W(128), .CTRL_W(16), .CLEAR_DATA(1'b0), .CNT_W(16)
    ) dut0 (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .up(up0), .dn(dn0), .stallCnt(stallCnt0)
    );

    pipe_stage_buff #(
        .DATA_W(128), .CTRL_W(16), .CLEAR_DATA(1'b1), .CNT_W(4)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .up(up1), .dn(dn1), .stallCnt(stallCnt1)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Set inputs for the next rising edge, then return on the following falling edge.
    task automatic applyStimulus(input logic v, input logic [127:0] d, input logic [15:0] c,
                                 input logic r, input logic f);
        inValid  = v;
        inData   = d;
        inCtrl   = c;
        outReady = r;
        flush    = f;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic compare(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output of both instances against hand-derived values.
    task automatic checkOutput(input string tag, input logic expValid, input logic expReady,
                               input logic [127:0] expData0, input logic [127:0] expData1,
                               input logic [15:0] expCtrl, input logic [15:0] expCnt0,
                               input logic [3:0] expCnt1);
        compare({tag, ".valid0"}, 128'(dn0.valid), 128'(expValid));
        compare({tag, ".ready0"}, 128'(up0.ready), 128'(expReady));
        compare({tag, ".data0"},  dn0.data,        expData0);
        compare({tag, ".ctrl0"},  128'(dn0.ctrl),  128'(expCtrl));
        compare({tag, ".cnt0"},   128'(stallCnt0), 128'(expCnt0));
        compare({tag, ".valid1"}, 128'(dn1.valid), 128'(expValid));
        compare({tag, ".ready1"}, 128'(up1.ready), 128'(expReady));
        compare({tag, ".data1"},  dn1.data,        expData1);
        compare({tag, ".ctrl1"},  128'(dn1.ctrl),  128'(expCtrl));
        compare({tag, ".cnt1"},   128'(stallCnt1), 128'(expCnt1));
    endtask

    // Directed sequence: reset, stream, back-pressure, flush, saturation, async reset.
    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b1;
        flush    = 1'b0;
        inValid  = 1'b0;
        inData   = '0;
        inCtrl   = '0;
        outReady = 1'b0;

        #1 reset_n = 1'b0;
        @(negedge clk);
        checkOutput("reset", 1'b0, 1'b1, 128'h0, 128'h0, 16'h0, 16'd0, 4'd0);
        @(negedge clk);
        reset_n = 1'b1;

        $display("[TB] stream");
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b1, 128'(k), 16'(k), 1'b1, 1'b0);
            checkOutput($sformatf("stream%0d", k), 1'b1, 1'b1, 128'(k), 128'(k), 16'(k),
                        16'd0, 4'd0);
        end
        applyStimulus(1'b0, 128'h0, 16'h0, 1'b1, 1'b0);
        checkOutput("streamEnd", 1'b0, 1'b1, 128'd8, 128'h0, 16'h0, 16'd0, 4'd0);

        $display("[TB] back-pressure");
        applyStimulus(1'b1, 128'd1, 16'd1, 1'b1, 1'b0);
        checkOutput("bp1", 1'b1, 1'b1, 128'd1, 128'd1, 16'd1, 16'd0, 4'd0);
        applyStimulus(1'b1, 128'd2, 16'd2, 1'b0, 1'b0);
        checkOutput("bpSkid", 1'b1, 1'b0, 128'd1, 128'd1, 16'd1, 16'd1, 4'd1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 128'd3, 16'd3, 1'b0, 1'b0);
            checkOutput($sformatf("bpHold%0d", i), 1'b1, 1'b0, 128'd1, 128'd1, 16'd1,
                        16'(2 + i), 4'(2 + i));
        end
        applyStimulus(1'b1, 128'd3, 16'd3, 1'b1, 1'b0);
        checkOutput("bpOut2", 1'b1, 1'b1, 128'd2, 128'd2, 16'd2, 16'd5, 4'd5);
        applyStimulus(1'b1, 128'd3, 16'd3, 1'b1, 1'b0);
        checkOutput("bpOut3", 1'b1, 1'b1, 128'd3, 128'd3, 16'd3, 16'd5, 4'd5);
        applyStimulus(1'b1, 128'd4, 16'd4, 1'b1, 1'b0);
        checkOutput("bpOut4", 1'b1, 1'b1, 128'd4, 128'd4, 16'd4, 16'd5, 4'd5);
        applyStimulus(1'b0, 128'h0, 16'h0, 1'b1, 1'b0);
        checkOutput("bpEnd", 1'b0, 1'b1, 128'd4, 128'h0, 16'h0, 16'd5, 4'd5);

        $display("[TB] flush in FULL");
        applyStimulus(1'b1, 128'hDEAD, 16'hDEAD, 1'b0, 1'b0);
        checkOutput("flA", 1'b1, 1'b1, 128'hDEAD, 128'hDEAD, 16'hDEAD, 16'd5, 4'd5);
        applyStimulus(1'b1, 128'hB0B, 16'hB0B, 1'b0, 1'b0);
        checkOutput("flB", 1'b1, 1'b0, 128'hDEAD, 128'hDEAD, 16'hDEAD, 16'd6, 4'd6);
        applyStimulus(1'b1, 128'hC0C, 16'hC0C, 1'b0, 1'b1);
        checkOutput("flush", 1'b0, 1'b1, 128'hDEAD, 128'h0, 16'h0, 16'd7, 4'd7);
        applyStimulus(1'b1, 128'h11, 16'h11, 1'b1, 1'b0);
        checkOutput("postFlush", 1'b1, 1'b1, 128'h11, 128'h11, 16'h11, 16'd7, 4'd7);
        applyStimulus(1'b0, 128'h0, 16'h0, 1'b1, 1'b0);
        checkOutput("postFlushEnd", 1'b0, 1'b1, 128'h11, 128'h0, 16'h0, 16'd7, 4'd7);

        $display("[TB] stall saturation");
        applyStimulus(1'b1, 128'h22, 16'h22, 1'b0, 1'b0);
        checkOutput("satLoad", 1'b1, 1'b1, 128'h22, 128'h22, 16'h22, 16'd7, 4'd7);
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(1'b0, 128'h0, 16'h0, 1'b0, 1'b0);
            checkOutput($sformatf("sat%0d", i), 1'b1, 1'b1, 128'h22, 128'h22, 16'h22,
                        16'(7 + i), (7 + i > 15) ? 4'd15 : 4'(7 + i));
        end

        $display("[TB] async reset while FULL");
        applyStimulus(1'b1, 128'h33, 16'h33, 1'b0, 1'b0);
        checkOutput("satFull", 1'b1, 1'b0, 128'h22, 128'h22, 16'h22, 16'd28, 4'd15);
        inValid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checkOutput("asyncRst", 1'b0, 1'b1, 128'h0, 128'h0, 16'h0, 16'd0, 4'd0);
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(1'b0, 128'h0, 16'h0, 1'b1, 1'b0);
        checkOutput("rstIdle", 1'b0, 1'b1, 128'h0, 128'h0, 16'h0, 16'd0, 4'd0);
        applyStimulus(1'b1, 128'h44, 16'h44, 1'b1, 1'b0);
        checkOutput("rstNew", 1'b1, 1'b1, 128'h44, 128'h44, 16'h44, 16'd0, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
